// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the iterative DES round sequencer.
// Shift tables hold the per-round C/D rotation amounts for each direction.
package des_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_ROUNDS_MAX = 16;

    localparam logic [1:0] ENC_SHIFT [NUM_ROUNDS_MAX] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt starts from the fully rotated key (28 places), so round 0 does not move it.
    localparam logic [1:0] DEC_SHIFT [NUM_ROUNDS_MAX] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_shift_rom.sv
// Combinational key-rotation lookup: round index and direction to shift amount.
// Also used by the key-schedule verifier, so it carries no gating of its own.
module des_shift_rom
    import des_ctrl_pkg::*;
(
    input  logic [3:0] round_idx_i,
    input  logic       mode_dec_i,
    output logic [1:0] shift_amt_o,
    output logic       shift_right_o
);

    always_comb begin
        shift_amt_o   = mode_dec_i ? DEC_SHIFT[round_idx_i] : ENC_SHIFT[round_idx_i];
        shift_right_o = mode_dec_i;
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for a one-round-per-clock DES engine: accepts a block, steps the
// round counter and key rotation, then holds the result until consumed.
module des_round_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter bit BACK2BACK  = 1'b1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       key_load_i,
    input  logic       mode_dec_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       ld_key_o,
    output logic       ld_data_o,
    output logic       round_en_o,
    output logic [3:0] round_idx_o,
    output logic [1:0] shift_amt_o,
    output logic       shift_right_o,
    output logic       out_en_o,
    output logic       busy_o,
    output logic       err_nokey_o
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       key_held_q, key_held_d;
    logic       mode_q, mode_d;

    logic       accept_win;
    logic       accept;
    logic       drop;
    logic       take;
    logic [1:0] rom_amt;
    logic       rom_right;

    // A block can enter from IDLE, or from DONE in the very cycle the result leaves.
    assign accept_win = (state_q == IDLE) ||
                        (BACK2BACK && (state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && accept_win;
    assign drop       = accept && !key_load_i && !key_held_q;
    assign take       = accept && !drop;

    des_shift_rom u_shift_rom (
        .round_idx_i   (cnt_q),
        .mode_dec_i    (mode_q),
        .shift_amt_o   (rom_amt),
        .shift_right_o (rom_right)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            key_held_q <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_held_q <= key_held_d;
            mode_q     <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_held_d = key_held_q;
        mode_d     = mode_q;
        if (take) begin
            cnt_d  = 4'd0;
            mode_d = mode_dec_i;
            if (key_load_i) key_held_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (take) state_d = ROUND;
            end
            ROUND: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = take ? ROUND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o    = 1'b0;
        out_valid_o   = 1'b0;
        round_en_o    = 1'b0;
        round_idx_o   = 4'd0;
        shift_amt_o   = 2'd0;
        shift_right_o = 1'b0;
        out_en_o      = 1'b0;
        busy_o        = 1'b0;
        ld_data_o     = take;
        ld_key_o      = take && key_load_i;
        err_nokey_o   = drop;
        case (state_q)
            IDLE: in_ready_o = 1'b1;
            ROUND: begin
                round_en_o    = 1'b1;
                round_idx_o   = cnt_q;
                shift_amt_o   = rom_amt;
                shift_right_o = rom_right;
                out_en_o      = (cnt_q == LAST_IDX);
                busy_o        = 1'b1;
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = BACK2BACK && out_ready_i;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Sequencer for an iterative DES engine that executes one Feistel round per clock, replacing the fully unrolled combinational path.
- Accepts a block (plus optional new key) over a valid/ready handshake and latches the encrypt/decrypt mode.
- Drives load strobes, round index, key-rotation amount/direction and output capture to the datapath, then presents the result over a valid/ready handshake.
- Sits between the system interface and the existing key/data/output registers.

Parameters:
NUM_ROUNDS, 16, rounds per block; must be 16 for DES conformance; 2..16 allowed for debug.
BACK2BACK, 1, 1 = a new block may be accepted in the same cycle the previous result is consumed.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  requester has a block
in_ready  out  1  controller can accept a block
key_load  in  1  qualifies in_valid: load key_in with this block
mode_dec  in  1  0 = encrypt, 1 = decrypt; sampled at accept
out_valid  out  1  result available in output register
out_ready  in  1  consumer takes result
ld_key  out  1  strobe: key register captures key_in
ld_data  out  1  strobe: data register captures data_in (IP applied)
round_en  out  1  datapath performs one round this cycle
round_idx  out  4  current round number, 0..NUM_ROUNDS-1
shift_amt  out  2  C/D rotation amount this round (0, 1 or 2)
shift_right  out  1  rotation direction: 1 = right (decrypt)
out_en  out  1  strobe: output register captures swapped R/L with FP applied
busy  out  1  block in flight (ROUND state)
err_nokey  out  1  one-cycle pulse: block dropped, no key held

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; counter 0; key_held 0; mode 0. All outputs 0 except in_ready = 1.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready.
    - ld_data = 1 combinationally in the accept cycle.
    - ld_key = key_load in the accept cycle.
    - mode_dec is latched.
    - If key_load = 1, key_held is set.
    - Next state ROUND, counter = 0.
  - Accept with key_load = 0 and key_held = 0: block dropped, err_nokey pulses, no ld_* strobes, state stays IDLE.
- ROUND:
  - round_en = 1, round_idx = counter, busy = 1, in_ready = 0.
  - Counter increments each cycle.
  - shift_amt/shift_right come from the latched mode and counter:
    - Encrypt (left): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - Decrypt (right): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - In the cycle where counter = NUM_ROUNDS-1, out_en = 1 and next state is DONE.
- DONE:
  - out_valid = 1, held stable until out_ready.
  - On out_valid && out_ready, next state is IDLE, unless BACK2BACK = 1 and in_valid = 1:
    - in_ready = out_ready in DONE.
    - The new block is accepted in the same cycle (same rules as IDLE, including the no-key drop, which returns to IDLE).
    - Next state ROUND.
- Latency: accept at cycle T → rounds at T+1..T+NUM_ROUNDS → out_valid at T+NUM_ROUNDS+1. Throughput is one block per NUM_ROUNDS+1 cycles with BACK2BACK.
- in_valid during ROUND or DONE without the consume condition is ignored (in_ready = 0). The requester holds the request.
- The key persists across blocks. key_load = 1 on a later accept replaces it.
- Reset mid-ROUND or mid-DONE aborts the block. No out_valid follows, and key_held clears.
- Counter width is 4 bits. It never wraps because it is cleared on every accept.

Decomposition:
- Package des_ctrl_pkg holds:
  - state enum {IDLE, ROUND, DONE};
  - NUM_ROUNDS_MAX = 16;
  - the encrypt and decrypt shift tables as 16×2-bit constants.
- Sub-module des_shift_rom: combinational (round_idx, mode_dec) → (shift_amt, shift_right), reused by the key-schedule verifier.

Test Plan:
- Reset sequence: reset low 3 cycles → in_ready = 1, out_valid = busy = round_en = 0. Then encrypt with key_load = 1, key 0x133457799BBCDFF1 and data 0x0123456789ABCDEF accepted at T → round_idx 0..15 at T+1..T+16, shift_amt 1,1,2,…,1, out_en at T+16, out_valid at T+17. Full datapath result = 0x85E813540F0AB405.
- Decrypt of 0x85E813540F0AB405 with key_load = 0 (key held) → shift_right = 1, shift_amt sequence 0,1,2,…,1, result 0x0123456789ABCDEF, ld_key never asserted.
- Accept after reset with key_load = 0 → err_nokey single pulse, no ld_data, state stays IDLE, in_ready = 1.
- Backpressure: out_ready = 0 for 5 cycles in DONE with in_valid = 1 → out_valid held and in_ready = 0. Then out_ready = 1 → consume and accept in the same cycle, round_idx = 0 next cycle.
- Reset asserted at round_idx = 7 → all outputs at reset values immediately. A later key_load = 0 request yields err_nokey.
- BACK2BACK = 0 build: consume with in_valid = 1 → in_ready = 0 in DONE. Accept occurs one cycle later from IDLE.
